uart_receiver: RTL and testbench

//   UART receiver, 8N1 format, LSB first, idle-high line.

---
 rtl/uart_receiver.sv | 130 +++++++++++++
 tb/tb_uart_receiver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling,
// one-cycle valid strobe per correctly framed byte.
module uart_receiver #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q;
  logic          rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          hit_half;
  logic          hit_full;

  assign hit_half = (cnt_q == HALF_M1);
  assign hit_full = (cnt_q == FULL_M1);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (hit_half) state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (hit_full && idx_q == 3'd7) state_d = S_STOP;
      end
      // Stop sampled mid-bit leaves half a bit to catch the next start.
      S_STOP: begin
        if (hit_full) state_d = rx_s_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
      end
      S_START: begin
        if (hit_half) begin
          cnt_d = '0;
          idx_d = '0;
        end
      end
      S_DATA: begin
        if (hit_full) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (hit_full) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame table with a byte-level reference
// model, plus glitch, framing and mid-frame reset sequences.
module tb_uart_receiver;

  localparam int CPB = 868;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;

  uart_receiver dut (
    .clock    (clock),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [7:0] d;
  } pulse_t;

  pulse_t obs[$];

  always @(negedge clock) begin
    pulse_t p;
    if (rx_valid) begin
      p.t = cyc;
      p.d = rx_data;
      obs.push_back(p);
    end
  end

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         cpb;
    int         gap;
    bit         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[5];

  int total = 0;
  int bad   = 0;
  int t_start;
  logic [7:0] last;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act,
                         input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Caller is aligned at posedge+#1; returns aligned the same way.
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stopv,
                            input int cpb);
    logic [9:0] fr;
    fr      = {stopv, d, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      idle(cpb);
    end
    rx = 1'b1;
  endtask

  task automatic check_frame(input string name, input bit ev,
                             input logic [7:0] ed);
    pulse_t p;
    chk({name, "_pulses"}, obs.size(), ev ? 1 : 0);
    if (ev && obs.size() > 0) begin
      p = obs.pop_front();
      chk({name, "_data"}, int'(p.d), int'(ed));
      chk_rng({name, "_lat"}, p.t - t_start, LAT - 2, LAT + 2);
    end
    chk({name, "_hold"}, int'(rx_data), int'(ed));
    obs.delete();
  endtask

  initial begin
    tbl[0] = '{8'hA5, 1'b1, CPB, 0, 1'b0, 8'h00};
    tbl[1] = '{8'h3C, 1'b1, CPB, CPB, 1'b0, 8'h00};
    tbl[2] = '{8'($urandom), 1'b1, int'($urandom_range(851, 885)),
               CPB, 1'b0, 8'h00};
    tbl[3] = '{8'h81, 1'b0, CPB, CPB, 1'b0, 8'h00};
    tbl[4] = '{8'h81, 1'b1, CPB, CPB, 1'b0, 8'h00};

    // Reference: a frame with a high stop bit delivers its byte,
    // anything else leaves the last good byte in place.
    last = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tbl[i].exp_valid = tbl[i].stop;
      if (tbl[i].stop) last = tbl[i].data;
      tbl[i].exp_data = last;
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", int'(rx_valid), 0);
    chk("rst_data", int'(rx_data), 0);
    @(posedge clock);
    #1 rst = 1'b0;

    idle(2000);
    chk("idle_pulses", obs.size(), 0);
    chk("idle_data", int'(rx_data), 0);
    obs.delete();

    last = 8'h00;
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].cpb);
      check_frame($sformatf("vec%0d", i), tbl[i].exp_valid,
                  tbl[i].exp_data);
      last = tbl[i].exp_data;
      idle(tbl[i].gap);
    end

    rx = 1'b0;
    idle(300);
    rx = 1'b1;
    idle(1000);
    chk("glitch_pulses", obs.size(), 0);
    chk("glitch_data", int'(rx_data), int'(last));
    obs.delete();
    send_frame(8'h5A, 1'b1, CPB);
    check_frame("after_glitch", 1'b1, 8'h5A);
    idle(CPB);

    rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(4 * CPB + CPB / 2);
    rst = 1'b1;
    idle(3);
    chk("midrst_valid", int'(rx_valid), 0);
    chk("midrst_data", int'(rx_data), 0);
    rst = 1'b0;
    idle(2 * CPB);
    chk("midrst_pulses", obs.size(), 0);
    obs.delete();
    send_frame(8'h00, 1'b1, CPB);
    check_frame("after_rst", 1'b1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
